fde_datapath: RTL and testbench



---
 rtl/fde_pkg.sv | 32 +++
 rtl/fde_alu.sv | 67 ++++++
 rtl/fde_datapath.sv | 138 +++++++++++++
 tb/tb_fde_datapath.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fde_pkg.sv
// Shared definitions for the fetch/decode/execute datapath:
// ALU op codes, forwarding select codes and instruction field positions.
package fde_pkg;

    typedef enum logic [2:0] {
        ALU_ADD  = 3'b000,
        ALU_SUB  = 3'b001,
        ALU_AND  = 3'b010,
        ALU_OR   = 3'b011,
        ALU_XOR  = 3'b100,
        ALU_SHL  = 3'b101,
        ALU_SHR  = 3'b110,
        ALU_PASS = 3'b111
    } alu_op_e;

    localparam logic [1:0] FWD_REG  = 2'b00;
    localparam logic [1:0] FWD_WB   = 2'b01;
    localparam logic [1:0] FWD_M    = 2'b10;
    localparam logic [1:0] FWD_REG3 = 2'b11;

    localparam int OPC_MSB = 23;
    localparam int OPC_LSB = 20;
    localparam int RD_MSB  = 19;
    localparam int RD_LSB  = 16;
    localparam int RS1_MSB = 15;
    localparam int RS1_LSB = 12;
    localparam int RS2_MSB = 11;
    localparam int RS2_LSB = 8;
    localparam int IMM_MSB = 11;
    localparam int IMM_W   = 12;

endpackage

// File: rtl/fde_alu.sv
// Execute-stage ALU: operand-B select, arithmetic/logic/shift ops
// and NZVC flag generation.
module fde_alu
    import fde_pkg::*;
#(
    parameter int WIDTH = 16
)(
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_fwd2,
    input  logic [WIDTH-1:0] i_imm,
    input  logic             i_b_sel_imm,
    input  logic [2:0]       i_alu_control,
    output logic [WIDTH-1:0] o_result,
    output logic             o_n,
    output logic             o_z,
    output logic             o_v,
    output logic             o_c
);

    localparam int M = WIDTH - 1;

    logic [WIDTH-1:0] w_b;
    logic [WIDTH:0]   w_add;
    logic [WIDTH:0]   w_sub;
    logic [WIDTH-1:0] w_res;
    logic             w_v;
    logic             w_c;

    assign w_b   = i_b_sel_imm ? i_imm : i_fwd2;
    assign w_add = {1'b0, i_a} + {1'b0, w_b};
    // SUB is A + ~B + 1 so the carry out means "no borrow"
    assign w_sub = {1'b0, i_a} + {1'b0, ~w_b}
                 + {{WIDTH{1'b0}}, 1'b1};

    // Operation select; carry/overflow only meaningful for ADD/SUB
    always_comb begin
        w_res = '0;
        w_v   = 1'b0;
        w_c   = 1'b0;
        case (alu_op_e'(i_alu_control))
            ALU_ADD: begin
                w_res = w_add[M:0];
                w_c   = w_add[WIDTH];
                w_v   = (i_a[M] == w_b[M]) && (w_add[M] != i_a[M]);
            end
            ALU_SUB: begin
                w_res = w_sub[M:0];
                w_c   = w_sub[WIDTH];
                w_v   = (i_a[M] != w_b[M]) && (w_sub[M] != i_a[M]);
            end
            ALU_AND:  w_res = i_a & w_b;
            ALU_OR:   w_res = i_a | w_b;
            ALU_XOR:  w_res = i_a ^ w_b;
            ALU_SHL:  w_res = i_a << w_b[3:0];
            ALU_SHR:  w_res = i_a >> w_b[3:0];
            ALU_PASS: w_res = w_b;
            default:  w_res = '0;
        endcase
    end

    assign o_result = w_res;
    assign o_n      = w_res[M];
    assign o_z      = (w_res == '0);
    assign o_v      = w_v;
    assign o_c      = w_c;

endmodule

// File: rtl/fde_datapath.sv
// Fetch/decode/execute datapath: PC, 16-entry register file with
// write-through bypass, field decode, forwarding muxes and the ALU.
module fde_datapath
    import fde_pkg::*;
#(
    parameter int WIDTH            = 16,
    parameter int REGNUM           = 16,
    parameter int ADDRESSWIDTH     = 4,
    parameter int OPCODEWIDTH      = 4,
    parameter int INSTRUCTIONWIDTH = 24
)(
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        pc_enable,
    input  logic                        take_branch,
    input  logic [WIDTH-1:0]            branch_target,
    output logic [WIDTH-1:0]            pc,
    input  logic [INSTRUCTIONWIDTH-1:0] instruction_d,
    input  logic [WIDTH-1:0]            pc_d,
    input  logic                        obtain_pc_as_r1,
    input  logic                        wb_write_enable,
    input  logic [ADDRESSWIDTH-1:0]     wb_address,
    input  logic [WIDTH-1:0]            wb_data,
    output logic [WIDTH-1:0]            reg1_content_d,
    output logic [WIDTH-1:0]            reg2_content_d,
    output logic [WIDTH-1:0]            immediate_d,
    output logic [ADDRESSWIDTH-1:0]     rd_address_d,
    output logic [ADDRESSWIDTH-1:0]     rs1_address_d,
    output logic [ADDRESSWIDTH-1:0]     rs2_address_d,
    output logic [OPCODEWIDTH-1:0]      opcode_d,
    input  logic [WIDTH-1:0]            reg1_content_e,
    input  logic [WIDTH-1:0]            reg2_content_e,
    input  logic [WIDTH-1:0]            immediate_e,
    input  logic [WIDTH-1:0]            forward_m,
    input  logic [WIDTH-1:0]            forward_wb,
    input  logic [2:0]                  alu_control_e,
    input  logic                        data2_selector_e,
    input  logic [1:0]                  data1_forward_sel_e,
    input  logic [1:0]                  data2_forward_sel_e,
    output logic [WIDTH-1:0]            alu_result_e,
    output logic [WIDTH-1:0]            store_data_e,
    output logic                        n_e,
    output logic                        z_e,
    output logic                        v_e,
    output logic                        c_e
);

    logic [WIDTH-1:0]        r_pc;
    logic [WIDTH-1:0]        r_regs [REGNUM];
    logic [ADDRESSWIDTH-1:0] w_rs1;
    logic [ADDRESSWIDTH-1:0] w_rs2;
    logic [WIDTH-1:0]        w_rd1;
    logic [WIDTH-1:0]        w_rd2;
    logic [WIDTH-1:0]        w_fwd1;
    logic [WIDTH-1:0]        w_fwd2;

    // PC: branch wins even while stalled, else increment when enabled
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_pc <= '0;
        end else if (take_branch) begin
            r_pc <= branch_target;
        end else if (pc_enable) begin
            r_pc <= r_pc + {{(WIDTH-1){1'b0}}, 1'b1};
        end
    end

    assign pc = r_pc;

    // Register file write port; every register is general purpose
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < REGNUM; i++) begin
                r_regs[i] <= '0;
            end
        end else if (wb_write_enable) begin
            r_regs[wb_address] <= wb_data;
        end
    end

    assign w_rs1 = instruction_d[RS1_MSB:RS1_LSB];
    assign w_rs2 = instruction_d[RS2_MSB:RS2_LSB];

    // Read ports with write-through bypass so same-cycle reads see wb_data
    always_comb begin
        w_rd1 = r_regs[w_rs1];
        w_rd2 = r_regs[w_rs2];
        if (wb_write_enable && wb_address == w_rs1) begin
            w_rd1 = wb_data;
        end
        if (wb_write_enable && wb_address == w_rs2) begin
            w_rd2 = wb_data;
        end
    end

    assign reg1_content_d = obtain_pc_as_r1 ? pc_d : w_rd1;
    assign reg2_content_d = w_rd2;
    assign opcode_d       = instruction_d[OPC_MSB:OPC_LSB];
    assign rd_address_d   = instruction_d[RD_MSB:RD_LSB];
    assign rs1_address_d  = w_rs1;
    assign rs2_address_d  = w_rs2;
    assign immediate_d    = {{(WIDTH-IMM_W){instruction_d[IMM_MSB]}},
                             instruction_d[IMM_MSB:0]};

    // Forwarding muxes; both 00 and 11 fall back to register content
    always_comb begin
        w_fwd1 = reg1_content_e;
        w_fwd2 = reg2_content_e;
        case (data1_forward_sel_e)
            FWD_WB:  w_fwd1 = forward_wb;
            FWD_M:   w_fwd1 = forward_m;
            default: w_fwd1 = reg1_content_e;
        endcase
        case (data2_forward_sel_e)
            FWD_WB:  w_fwd2 = forward_wb;
            FWD_M:   w_fwd2 = forward_m;
            default: w_fwd2 = reg2_content_e;
        endcase
    end

    assign store_data_e = w_fwd2;

    fde_alu #(
        .WIDTH (WIDTH)
    ) u_alu (
        .i_a           (w_fwd1),
        .i_fwd2        (w_fwd2),
        .i_imm         (immediate_e),
        .i_b_sel_imm   (data2_selector_e),
        .i_alu_control (alu_control_e),
        .o_result      (alu_result_e),
        .o_n           (n_e),
        .o_z           (z_e),
        .o_v           (v_e),
        .o_c           (c_e)
    );

endmodule

// File: tb/tb_fde_datapath.sv
// Directed bench for fde_datapath: ALU/decode vector tables plus
// hand-written PC, register-file, forwarding and reset sequences.
module tb_fde_datapath;

    logic        clock;
    logic        reset;
    logic        pc_enable;
    logic        take_branch;
    logic [15:0] branch_target;
    logic [15:0] pc;
    logic [23:0] instruction_d;
    logic [15:0] pc_d;
    logic        obtain_pc_as_r1;
    logic        wb_write_enable;
    logic [3:0]  wb_address;
    logic [15:0] wb_data;
    logic [15:0] reg1_content_d;
    logic [15:0] reg2_content_d;
    logic [15:0] immediate_d;
    logic [3:0]  rd_address_d;
    logic [3:0]  rs1_address_d;
    logic [3:0]  rs2_address_d;
    logic [3:0]  opcode_d;
    logic [15:0] reg1_content_e;
    logic [15:0] reg2_content_e;
    logic [15:0] immediate_e;
    logic [15:0] forward_m;
    logic [15:0] forward_wb;
    logic [2:0]  alu_control_e;
    logic        data2_selector_e;
    logic [1:0]  data1_forward_sel_e;
    logic [1:0]  data2_forward_sel_e;
    logic [15:0] alu_result_e;
    logic [15:0] store_data_e;
    logic        n_e;
    logic        z_e;
    logic        v_e;
    logic        c_e;

    int n_vec;
    int n_err;

    fde_datapath dut (
        .clock               (clock),
        .reset               (reset),
        .pc_enable           (pc_enable),
        .take_branch         (take_branch),
        .branch_target       (branch_target),
        .pc                  (pc),
        .instruction_d       (instruction_d),
        .pc_d                (pc_d),
        .obtain_pc_as_r1     (obtain_pc_as_r1),
        .wb_write_enable     (wb_write_enable),
        .wb_address          (wb_address),
        .wb_data             (wb_data),
        .reg1_content_d      (reg1_content_d),
        .reg2_content_d      (reg2_content_d),
        .immediate_d         (immediate_d),
        .rd_address_d        (rd_address_d),
        .rs1_address_d       (rs1_address_d),
        .rs2_address_d       (rs2_address_d),
        .opcode_d            (opcode_d),
        .reg1_content_e      (reg1_content_e),
        .reg2_content_e      (reg2_content_e),
        .immediate_e         (immediate_e),
        .forward_m           (forward_m),
        .forward_wb          (forward_wb),
        .alu_control_e       (alu_control_e),
        .data2_selector_e    (data2_selector_e),
        .data1_forward_sel_e (data1_forward_sel_e),
        .data2_forward_sel_e (data2_forward_sel_e),
        .alu_result_e        (alu_result_e),
        .store_data_e        (store_data_e),
        .n_e                 (n_e),
        .z_e                 (z_e),
        .v_e                 (v_e),
        .c_e                 (c_e)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    typedef struct {
        logic [2:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] res;
        logic [3:0]  nzvc;
    } alu_vec_t;

    typedef struct {
        logic [23:0] instr;
        logic [3:0]  opc;
        logic [3:0]  rd;
        logic [3:0]  rs1;
        logic [3:0]  rs2;
        logic [15:0] imm;
    } dec_vec_t;

    alu_vec_t alu_tab [11];
    dec_vec_t dec_tab [2];

    initial begin
        n_vec = 0;
        n_err = 0;

        alu_tab[0]  = '{3'b000, 16'h7FFF, 16'h0001, 16'h8000, 4'b1010};
        alu_tab[1]  = '{3'b001, 16'h0005, 16'h0005, 16'h0000, 4'b0101};
        alu_tab[2]  = '{3'b000, 16'hFFFF, 16'h0001, 16'h0000, 4'b0101};
        alu_tab[3]  = '{3'b101, 16'h0001, 16'h0004, 16'h0010, 4'b0000};
        alu_tab[4]  = '{3'b110, 16'h8000, 16'h000F, 16'h0001, 4'b0000};
        alu_tab[5]  = '{3'b100, 16'hFF00, 16'h0FF0, 16'hF0F0, 4'b1000};
        alu_tab[6]  = '{3'b010, 16'hF0F0, 16'h0FF0, 16'h00F0, 4'b0000};
        alu_tab[7]  = '{3'b011, 16'h1200, 16'h0034, 16'h1234, 4'b0000};
        alu_tab[8]  = '{3'b111, 16'h1111, 16'hABCD, 16'hABCD, 4'b1000};
        alu_tab[9]  = '{3'b001, 16'h0003, 16'h0005, 16'hFFFE, 4'b1000};
        alu_tab[10] = '{3'b001, 16'h8000, 16'h0001, 16'h7FFF, 4'b0011};

        dec_tab[0] = '{24'h35A123, 4'h3, 4'h5, 4'hA, 4'h1, 16'h0123};
        dec_tab[1] = '{24'h100F00, 4'h1, 4'h0, 4'h0, 4'hF, 16'hFF00};

        reset               = 1'b0;
        pc_enable           = 1'b0;
        take_branch         = 1'b0;
        branch_target       = '0;
        instruction_d       = 24'h000000;
        pc_d                = '0;
        obtain_pc_as_r1     = 1'b0;
        wb_write_enable     = 1'b0;
        wb_address          = '0;
        wb_data             = '0;
        reg1_content_e      = '0;
        reg2_content_e      = '0;
        immediate_e         = '0;
        forward_m           = '0;
        forward_wb          = '0;
        alu_control_e       = '0;
        data2_selector_e    = 1'b0;
        data1_forward_sel_e = 2'b00;
        data2_forward_sel_e = 2'b00;

        // reset state
        @(negedge clock);
        check("reset_pc", {16'h0, pc}, 32'h0);
        instruction_d = 24'h00F300;
        #1;
        check("reset_r15", {16'h0, reg1_content_d}, 32'h0);
        check("reset_r3", {16'h0, reg2_content_d}, 32'h0);

        // increment sequence
        reset     = 1'b1;
        pc_enable = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            @(negedge clock);
            check("pc_inc", {16'h0, pc}, i);
        end
        pc_enable = 1'b0;
        @(negedge clock);
        check("pc_hold", {16'h0, pc}, 32'h3);

        // branch while stalled, then wrap
        take_branch   = 1'b1;
        branch_target = 16'h0040;
        @(negedge clock);
        check("pc_branch", {16'h0, pc}, 32'h40);
        branch_target = 16'hFFFF;
        @(negedge clock);
        check("pc_br_ffff", {16'h0, pc}, 32'hFFFF);
        take_branch = 1'b0;
        pc_enable   = 1'b1;
        @(negedge clock);
        check("pc_wrap", {16'h0, pc}, 32'h0);
        pc_enable = 1'b0;

        // register write with same-cycle bypass
        wb_write_enable = 1'b1;
        wb_address      = 4'h5;
        wb_data         = 16'h1234;
        instruction_d   = 24'h005000;
        #1;
        check("rf_bypass", {16'h0, reg1_content_d}, 32'h1234);
        @(negedge clock);
        wb_write_enable = 1'b0;
        wb_data         = 16'hDEAD;
        #1;
        check("rf_stored", {16'h0, reg1_content_d}, 32'h1234);
        instruction_d = 24'h000500;
        #1;
        check("rf_port2", {16'h0, reg2_content_d}, 32'h1234);
        instruction_d   = 24'h005000;
        obtain_pc_as_r1 = 1'b1;
        pc_d            = 16'h0010;
        #1;
        check("pc_as_r1", {16'h0, reg1_content_d}, 32'h0010);
        check("pc_as_r1_rs1", {28'h0, rs1_address_d}, 32'h5);
        obtain_pc_as_r1 = 1'b0;

        // decode table
        for (int i = 0; i < 2; i++) begin
            instruction_d = dec_tab[i].instr;
            #1;
            check("dec_opc", {28'h0, opcode_d}, {28'h0, dec_tab[i].opc});
            check("dec_rd", {28'h0, rd_address_d}, {28'h0, dec_tab[i].rd});
            check("dec_rs1", {28'h0, rs1_address_d}, {28'h0, dec_tab[i].rs1});
            check("dec_rs2", {28'h0, rs2_address_d}, {28'h0, dec_tab[i].rs2});
            check("dec_imm", {16'h0, immediate_d}, {16'h0, dec_tab[i].imm});
        end

        // ALU table
        for (int i = 0; i < 11; i++) begin
            alu_control_e  = alu_tab[i].op;
            reg1_content_e = alu_tab[i].a;
            reg2_content_e = alu_tab[i].b;
            #1;
            check($sformatf("alu_res[%0d]", i), {16'h0, alu_result_e},
                  {16'h0, alu_tab[i].res});
            check($sformatf("alu_nzvc[%0d]", i), {28'h0, n_e, z_e, v_e, c_e},
                  {28'h0, alu_tab[i].nzvc});
        end

        // forwarding
        reg1_content_e      = 16'h0001;
        reg2_content_e      = 16'h0002;
        forward_m           = 16'h0007;
        forward_wb          = 16'h0003;
        data1_forward_sel_e = 2'b10;
        data2_forward_sel_e = 2'b01;
        alu_control_e       = 3'b001;
        #1;
        check("fwd_sub", {16'h0, alu_result_e}, 32'h4);
        check("fwd_store", {16'h0, store_data_e}, 32'h3);
        data1_forward_sel_e = 2'b11;
        data2_forward_sel_e = 2'b11;
        alu_control_e       = 3'b000;
        #1;
        check("fwd11_add", {16'h0, alu_result_e}, 32'h3);
        check("fwd11_store", {16'h0, store_data_e}, 32'h2);
        data1_forward_sel_e = 2'b01;
        data2_forward_sel_e = 2'b10;
        alu_control_e       = 3'b001;
        #1;
        check("fwd_swap", {16'h0, alu_result_e}, 32'hFFFC);
        check("fwd_swap_st", {16'h0, store_data_e}, 32'h7);
        data2_selector_e = 1'b1;
        immediate_e      = 16'h0009;
        alu_control_e    = 3'b111;
        #1;
        check("imm_pass", {16'h0, alu_result_e}, 32'h9);
        check("imm_store", {16'h0, store_data_e}, 32'h7);

        // asynchronous reset mid-operation
        @(negedge clock);
        wb_write_enable = 1'b1;
        wb_address      = 4'h7;
        wb_data         = 16'h5555;
        pc_enable       = 1'b1;
        @(negedge clock);
        wb_write_enable = 1'b0;
        instruction_d   = 24'h007000;
        #1;
        check("r7_written", {16'h0, reg1_content_d}, 32'h5555);
        #1;
        reset = 1'b0;
        #1;
        check("async_pc", {16'h0, pc}, 32'h0);
        check("async_r7", {16'h0, reg1_content_d}, 32'h0);
        @(negedge clock);
        check("held_in_rst", {16'h0, pc}, 32'h0);
        reset = 1'b1;
        @(negedge clock);
        check("post_rst_inc", {16'h0, pc}, 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
